sargantana_tag_ctrl: RTL and testbench

- Initiator for the icache tag way memories: issues reads, refill writes and flush pulses to NUM_WAYS tag ways.
- Compares the returned tags and valid bits against the lookup tag and reports hit/way, or a victim way on a miss.
- Sits between the icache lookup pipeline / refill logic and the per-way tag arrays.

---
 rtl/sargantana_icache_pkg.sv | 14 +
 rtl/sargantana_tag_victim_sel.sv | 31 +++
 rtl/sargantana_tag_ctrl.sv | 147 ++++++++++++++
 tb/tb_sargantana_tag_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sargantana_icache_pkg.sv
// Shared icache constants and the tag controller state type.
package sargantana_icache_pkg;

   localparam int TAG_WIDHT      = 20;
   localparam int TAG_ADDR_WIDHT = 6;
   localparam int ICACHE_N_WAY   = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      FLUSH   = 2'd2
   } tag_ctrl_state_e;

endpackage

// File: rtl/sargantana_tag_victim_sel.sv
// Miss victim picker: lowest invalid way, otherwise a round-robin pointer
// that only moves on a miss where every way was valid.
module sargantana_tag_victim_sel #(
   parameter int NUM_WAYS = 4,
   parameter int WAY_W    = $clog2(NUM_WAYS)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NUM_WAYS-1:0] vbit_i,
   input  logic                advance_i,
   input  logic                clear_i,
   output logic [WAY_W-1:0]    victim_o
);

   logic [WAY_W-1:0] rr_q;

   // Round-robin pointer; wraps naturally since NUM_WAYS is a power of two.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) rr_q <= '0;
      else if (advance_i)   rr_q <= rr_q + 1'b1;
   end

   // Prefer the lowest free way; fall back to the pointer when the set is full.
   always_comb begin
      victim_o = rr_q;
      for (int w = NUM_WAYS-1; w >= 0; w--) begin
         if (!vbit_i[w]) victim_o = WAY_W'(w);
      end
   end

endmodule

// File: rtl/sargantana_tag_ctrl.sv
// Icache tag-way controller: issues tag reads/refill writes/flush pulses to
// all ways and resolves hit way or miss victim one cycle after a lookup.
// Optional macro SARGANTANA_TAG_MULTIHIT_CHECK_EN builds a sticky
// multiple-way-hit error flag; otherwise err_multihit_o is tied low.
module sargantana_tag_ctrl
   import sargantana_icache_pkg::*;
#(
   parameter int NUM_WAYS = ICACHE_N_WAY,
   parameter int TAG_W    = TAG_WIDHT,
   parameter int IDX_W    = TAG_ADDR_WIDHT,
   parameter int WAY_W    = $clog2(NUM_WAYS)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      lookup_valid_i,
   output logic                      lookup_ready_o,
   input  logic [IDX_W-1:0]          lookup_idx_i,
   input  logic [TAG_W-1:0]          lookup_tag_i,
   output logic                      resp_valid_o,
   output logic                      resp_hit_o,
   output logic [WAY_W-1:0]          resp_way_o,
   input  logic                      refill_valid_i,
   output logic                      refill_ready_o,
   input  logic [IDX_W-1:0]          refill_idx_i,
   input  logic [TAG_W-1:0]          refill_tag_i,
   input  logic [WAY_W-1:0]          refill_way_i,
   input  logic                      flush_i,
   output logic [NUM_WAYS-1:0]       tag_req_o,
   output logic                      tag_we_o,
   output logic                      tag_vbit_o,
   output logic                      tag_flush_o,
   output logic [TAG_W-1:0]          tag_data_o,
   output logic [IDX_W-1:0]          tag_addr_o,
   input  logic [NUM_WAYS*TAG_W-1:0] tag_data_i,
   input  logic [NUM_WAYS-1:0]       tag_vbit_i,
   output logic                      err_multihit_o
);

   tag_ctrl_state_e     state_q, state_d;
   logic [TAG_W-1:0]    lookup_tag_q;
   logic                lookup_fire;
   logic                resp_fire;
   logic [NUM_WAYS-1:0] hit_vec;
   logic                any_hit;
   logic [WAY_W-1:0]    hit_way;
   logic [WAY_W-1:0]    victim_way;

   // Per-way tag compare against the latched lookup tag.
   for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      assign hit_vec[w] = tag_vbit_i[w] & (tag_data_i[w*TAG_W +: TAG_W] == lookup_tag_q);
   end

   assign any_hit = |hit_vec;

   // Reset or flush in the compare cycle drops the response.
   assign resp_fire = (state_q == COMPARE) & ~flush_i & ~rst_i;

   // Lowest-index hitting way wins.
   always_comb begin
      hit_way = '0;
      for (int w = NUM_WAYS-1; w >= 0; w--) begin
         if (hit_vec[w]) hit_way = WAY_W'(w);
      end
   end

   sargantana_tag_victim_sel #(
      .NUM_WAYS (NUM_WAYS),
      .WAY_W    (WAY_W)
   ) u_victim_sel (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .vbit_i    (tag_vbit_i),
      .advance_i (resp_fire & ~any_hit & (&tag_vbit_i)),
      .clear_i   (flush_i),
      .victim_o  (victim_way)
   );

   assign resp_valid_o = resp_fire;
   assign resp_hit_o   = resp_fire & any_hit;
   assign resp_way_o   = !resp_fire ? '0 : (any_hit ? hit_way : victim_way);
   assign tag_flush_o  = flush_i & ~rst_i;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Lookup tag is held for the compare cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i)            lookup_tag_q <= '0;
      else if (lookup_fire) lookup_tag_q <= lookup_tag_i;
   end

   // Next state and tag-memory request; flush overrides everything, refill beats lookup.
   always_comb begin
      state_d        = state_q;
      lookup_ready_o = 1'b0;
      refill_ready_o = 1'b0;
      lookup_fire    = 1'b0;
      tag_req_o      = '0;
      tag_we_o       = 1'b0;
      tag_vbit_o     = 1'b0;
      tag_data_o     = '0;
      tag_addr_o     = '0;
      if (flush_i) begin
         state_d = FLUSH;
      end else begin
         case (state_q)
            IDLE: begin
               refill_ready_o = ~rst_i;
               lookup_ready_o = ~rst_i & ~refill_valid_i;
               if (refill_valid_i && !rst_i) begin
                  tag_req_o[refill_way_i] = 1'b1;
                  tag_we_o                = 1'b1;
                  tag_vbit_o              = 1'b1;
                  tag_addr_o              = refill_idx_i;
                  tag_data_o              = refill_tag_i;
               end else if (lookup_valid_i && !rst_i) begin
                  lookup_fire = 1'b1;
                  tag_req_o   = '1;
                  tag_addr_o  = lookup_idx_i;
                  state_d     = COMPARE;
               end
            end
            COMPARE: state_d = IDLE;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

`ifdef SARGANTANA_TAG_MULTIHIT_CHECK_EN
   logic err_q;

   // Sticky flag: more than one way matched; cleared by reset or flush.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i)                               err_q <= 1'b0;
      else if (resp_fire && ((hit_vec & (hit_vec - 1'b1)) != '0)) err_q <= 1'b1;
   end

   assign err_multihit_o = err_q;
`else
   assign err_multihit_o = 1'b0;
`endif

endmodule

// File: tb/tb_sargantana_tag_ctrl.sv
// Bench for sargantana_tag_ctrl: behavioural tag memory plus a reference
// model of hit/victim/round-robin/multihit rules, directed and random tests.
module tb_sargantana_tag_ctrl;
   import sargantana_icache_pkg::*;

   localparam int NW   = ICACHE_N_WAY;
   localparam int TW   = TAG_WIDHT;
   localparam int IW   = TAG_ADDR_WIDHT;
   localparam int WW   = $clog2(NW);
   localparam int SETS = 1 << IW;
`ifdef SARGANTANA_TAG_MULTIHIT_CHECK_EN
   localparam bit MH = 1'b1;
`else
   localparam bit MH = 1'b0;
`endif

   logic clk, rst;
   logic lookup_valid, lookup_ready;
   logic [IW-1:0] lookup_idx;
   logic [TW-1:0] lookup_tag;
   logic resp_valid, resp_hit;
   logic [WW-1:0] resp_way;
   logic refill_valid, refill_ready;
   logic [IW-1:0] refill_idx;
   logic [TW-1:0] refill_tag;
   logic [WW-1:0] refill_way;
   logic flush;
   logic [NW-1:0] tag_req;
   logic tag_we, tag_vbit, tag_flush;
   logic [TW-1:0] tag_data;
   logic [IW-1:0] tag_addr;
   logic [NW*TW-1:0] tag_rdata;
   logic [NW-1:0] tag_rvbit;
   logic err_mh;

   int errors = 0;
   int checks = 0;

   sargantana_tag_ctrl dut (
      .clk_i(clk), .rst_i(rst),
      .lookup_valid_i(lookup_valid), .lookup_ready_o(lookup_ready),
      .lookup_idx_i(lookup_idx), .lookup_tag_i(lookup_tag),
      .resp_valid_o(resp_valid), .resp_hit_o(resp_hit), .resp_way_o(resp_way),
      .refill_valid_i(refill_valid), .refill_ready_o(refill_ready),
      .refill_idx_i(refill_idx), .refill_tag_i(refill_tag), .refill_way_i(refill_way),
      .flush_i(flush),
      .tag_req_o(tag_req), .tag_we_o(tag_we), .tag_vbit_o(tag_vbit),
      .tag_flush_o(tag_flush), .tag_data_o(tag_data), .tag_addr_o(tag_addr),
      .tag_data_i(tag_rdata), .tag_vbit_i(tag_rvbit),
      .err_multihit_o(err_mh)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tag way memories driven by the DUT's request outputs (1-cycle read latency).
   logic [TW-1:0] mem_tag [NW][SETS];
   logic          mem_v   [NW][SETS];

   always @(posedge clk) begin
      for (int w = 0; w < NW; w++) begin
         if (tag_req[w] && !tag_we) begin
            tag_rdata[w*TW +: TW] <= mem_tag[w][tag_addr];
            tag_rvbit[w]          <= mem_v[w][tag_addr];
         end else begin
            tag_rdata[w*TW +: TW] <= TW'($urandom);
            tag_rvbit[w]          <= 1'($urandom);
         end
         if (tag_flush) begin
            for (int s = 0; s < SETS; s++) mem_v[w][s] <= 1'b0;
         end else if (tag_req[w] && tag_we) begin
            mem_tag[w][tag_addr] <= tag_data;
            mem_v[w][tag_addr]   <= tag_vbit;
         end
      end
   end

   // Reference state: what the cache should contain and how the rules resolve.
   logic [TW-1:0] ref_tag [NW][SETS];
   bit            ref_v   [NW][SETS];
   int            rr;
   bit            exp_err;

   task automatic model_lookup(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                               output bit hit, output logic [WW-1:0] way);
      int n = 0;
      int first = -1;
      int free = -1;
      for (int w = 0; w < NW; w++) begin
         if (ref_v[w][idx] && ref_tag[w][idx] == tag) begin
            n++;
            if (first < 0) first = w;
         end
         if (!ref_v[w][idx] && free < 0) free = w;
      end
      if (n > 0) begin
         hit = 1'b1;
         way = WW'(first);
         if (n > 1 && MH) exp_err = 1'b1;
      end else begin
         hit = 1'b0;
         if (free >= 0) way = WW'(free);
         else begin
            way = WW'(rr);
            rr  = (rr + 1) % NW;
         end
      end
   endtask

   task automatic model_flush();
      for (int w = 0; w < NW; w++)
         for (int s = 0; s < SETS; s++) ref_v[w][s] = 1'b0;
      rr      = 0;
      exp_err = 1'b0;
   endtask

   task automatic do_refill(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                            input logic [WW-1:0] way);
      logic [NW-1:0] er;
      er = '0;
      er[way] = 1'b1;
      @(negedge clk);
      refill_valid = 1'b1; refill_idx = idx; refill_tag = tag; refill_way = way;
      #1;
      checks++;
      if ({refill_ready, tag_req, tag_we, tag_vbit, tag_addr, tag_data} !== {1'b1, er, 1'b1, 1'b1, idx, tag}) begin
         errors++;
         $display("FAIL refill_issue: got rdy=%b req=%b we=%b vb=%b addr=%0d data=%h, want rdy=1 req=%b we=1 vb=1 addr=%0d data=%h",
                  refill_ready, tag_req, tag_we, tag_vbit, tag_addr, tag_data, er, idx, tag);
      end
      @(posedge clk); #1;
      refill_valid = 1'b0;
      ref_tag[way][idx] = tag;
      ref_v[way][idx]   = 1'b1;
   endtask

   task automatic do_lookup(input logic [IW-1:0] idx, input logic [TW-1:0] tag);
      bit eh;
      logic [WW-1:0] ew;
      @(negedge clk);
      lookup_valid = 1'b1; lookup_idx = idx; lookup_tag = tag;
      #1;
      checks++;
      if ({lookup_ready, tag_req, tag_we, tag_addr} !== {1'b1, {NW{1'b1}}, 1'b0, idx}) begin
         errors++;
         $display("FAIL lookup_issue: got rdy=%b req=%b we=%b addr=%0d, want rdy=1 req=all we=0 addr=%0d",
                  lookup_ready, tag_req, tag_we, tag_addr, idx);
      end
      @(posedge clk); #1;
      lookup_valid = 1'b0;
      model_lookup(idx, tag, eh, ew);
      @(negedge clk);
      checks++;
      if ({resp_valid, resp_hit, resp_way, lookup_ready, refill_ready} !== {1'b1, eh, ew, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL lookup_resp idx=%0d tag=%h: got v=%b hit=%b way=%0d rdy=%b/%b, want v=1 hit=%b way=%0d rdy=0/0",
                  idx, tag, resp_valid, resp_hit, resp_way, lookup_ready, refill_ready, eh, ew);
      end
      @(posedge clk); #1;
      checks++;
      if ({resp_valid, err_mh} !== {1'b0, exp_err}) begin
         errors++;
         $display("FAIL post_resp: got resp_valid=%b err=%b, want resp_valid=0 err=%b", resp_valid, err_mh, exp_err);
      end
   endtask

   task automatic do_flush();
      @(negedge clk);
      flush = 1'b1;
      #1;
      checks++;
      if ({tag_flush, lookup_ready, refill_ready, tag_req} !== {1'b1, 1'b0, 1'b0, {NW{1'b0}}}) begin
         errors++;
         $display("FAIL flush_pulse: got flush=%b rdy=%b/%b req=%b, want 1 0/0 0", tag_flush, lookup_ready, refill_ready, tag_req);
      end
      @(posedge clk); #1;
      flush = 1'b0;
      model_flush();
      @(negedge clk);
      checks++;
      if ({tag_flush, lookup_ready, refill_ready, tag_req, err_mh} !== {1'b0, 1'b0, 1'b0, {NW{1'b0}}, 1'b0}) begin
         errors++;
         $display("FAIL flush_state: got flush=%b rdy=%b/%b req=%b err=%b, want all 0", tag_flush, lookup_ready, refill_ready, tag_req, err_mh);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      flush = 1'b1;
      #1;
      checks++;
      if ({resp_valid, err_mh, tag_req, tag_we, tag_flush} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b err=%b req=%b we=%b flush=%b, want all 0", resp_valid, err_mh, tag_req, tag_we, tag_flush);
      end
      @(posedge clk); #1;
      rst = 1'b0; flush = 1'b0;
      @(negedge clk);
      checks++;
      if ({refill_ready, lookup_ready, resp_valid, err_mh} !== 4'b1100) begin
         errors++;
         $display("FAIL reset_idle: got rr=%b lr=%b v=%b err=%b, want 1 1 0 0", refill_ready, lookup_ready, resp_valid, err_mh);
      end
   endtask

   task automatic test_hit();
      do_refill(6'd5, 20'h01A2B, 2'd2);
      do_lookup(6'd5, 20'h01A2B);
   endtask

   task automatic test_partial_miss();
      do_refill(6'd3, 20'h00111, 2'd0);
      do_refill(6'd3, 20'h00222, 2'd1);
      do_lookup(6'd3, 20'h00333);
   endtask

   task automatic test_round_robin();
      for (int w = 0; w < NW; w++) do_refill(6'd7, 20'h0A000 + 20'(w), WW'(w));
      for (int i = 0; i < NW + 1; i++) do_lookup(6'd7, 20'h0BEEF);
   endtask

   task automatic test_flush_abort();
      do_lookup(6'd7, 20'h0CAFE);
      @(negedge clk);
      lookup_valid = 1'b1; lookup_idx = 6'd7; lookup_tag = 20'h0CAFE;
      @(posedge clk); #1;
      lookup_valid = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      checks++;
      if ({resp_valid, tag_flush, lookup_ready, refill_ready} !== 4'b0100) begin
         errors++;
         $display("FAIL flush_abort: got v=%b flush=%b rdy=%b/%b, want 0 1 0/0", resp_valid, tag_flush, lookup_ready, refill_ready);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({tag_flush, lookup_ready, refill_ready} !== 3'b100) begin
         errors++;
         $display("FAIL flush_hold: got flush=%b rdy=%b/%b, want 1 0/0", tag_flush, lookup_ready, refill_ready);
      end
      @(posedge clk); #1;
      flush = 1'b0;
      model_flush();
      @(negedge clk);
      checks++;
      if ({lookup_ready, refill_ready, tag_req} !== '0) begin
         errors++;
         $display("FAIL flush_cycle: got rdy=%b/%b req=%b, want 0", lookup_ready, refill_ready, tag_req);
      end
      do_lookup(6'd7, 20'h0CAFE);
      for (int w = 0; w < NW; w++) do_refill(6'd7, 20'h0D000 + 20'(w), WW'(w));
      do_lookup(6'd7, 20'h0CAFE);
   endtask

   task automatic test_priority();
      @(negedge clk);
      refill_valid = 1'b1; refill_idx = 6'd11; refill_tag = 20'h05555; refill_way = 2'd0;
      lookup_valid = 1'b1; lookup_idx = 6'd11; lookup_tag = 20'h05555;
      #1;
      checks++;
      if ({refill_ready, lookup_ready, tag_we, tag_req} !== {1'b1, 1'b0, 1'b1, 4'b0001}) begin
         errors++;
         $display("FAIL prio_refill: got rr=%b lr=%b we=%b req=%b, want 1 0 1 0001", refill_ready, lookup_ready, tag_we, tag_req);
      end
      @(posedge clk); #1;
      refill_valid = 1'b0;
      ref_tag[0][11] = 20'h05555;
      ref_v[0][11]   = 1'b1;
      @(negedge clk);
      checks++;
      if ({lookup_ready, tag_req, tag_we, tag_addr} !== {1'b1, 4'b1111, 1'b0, 6'd11}) begin
         errors++;
         $display("FAIL prio_lookup: got lr=%b req=%b we=%b addr=%0d, want 1 1111 0 11", lookup_ready, tag_req, tag_we, tag_addr);
      end
      @(posedge clk); #1;
      lookup_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({resp_valid, resp_hit, resp_way} !== {1'b1, 1'b1, 2'd0}) begin
         errors++;
         $display("FAIL prio_resp: got v=%b hit=%b way=%0d, want 1 1 0", resp_valid, resp_hit, resp_way);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_multihit();
      do_refill(6'd9, 20'h00777, 2'd1);
      do_refill(6'd9, 20'h00777, 2'd3);
      do_lookup(6'd9, 20'h00777);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (err_mh !== MH) begin
         errors++;
         $display("FAIL multihit_sticky: got err=%b, want %b", err_mh, MH);
      end
      do_flush();
   endtask

   task automatic test_reset_mid_compare();
      do_refill(6'd2, 20'h04444, 2'd1);
      @(negedge clk);
      lookup_valid = 1'b1; lookup_idx = 6'd2; lookup_tag = 20'h04444;
      @(posedge clk); #1;
      lookup_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({resp_valid, resp_hit} !== 2'b00) begin
         errors++;
         $display("FAIL rst_compare: got v=%b hit=%b, want 0 0", resp_valid, resp_hit);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      rr = 0;
      exp_err = 1'b0;
      @(negedge clk);
      checks++;
      if ({lookup_ready, refill_ready, resp_valid} !== 3'b110) begin
         errors++;
         $display("FAIL rst_idle: got lr=%b rr=%b v=%b, want 1 1 0", lookup_ready, refill_ready, resp_valid);
      end
      do_lookup(6'd2, 20'h04444);
   endtask

   task automatic test_random();
      logic [TW-1:0] pool [4];
      pool[0] = 20'h10001; pool[1] = 20'h20002; pool[2] = 20'h30003; pool[3] = 20'h40004;
      for (int i = 0; i < 250; i++) begin
         int op;
         op = $urandom_range(0, 19);
         if (op == 0) do_flush();
         else if (op < 9)
            do_refill(IW'(16 + $urandom_range(0, 3)), pool[$urandom_range(0, 3)], WW'($urandom_range(0, NW-1)));
         else
            do_lookup(IW'(16 + $urandom_range(0, 3)), pool[$urandom_range(0, 3)]);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0;
      lookup_valid = 1'b0; lookup_idx = '0; lookup_tag = '0;
      refill_valid = 1'b0; refill_idx = '0; refill_tag = '0; refill_way = '0;
      tag_rdata = '0; tag_rvbit = '0;
      rr = 0; exp_err = 1'b0;
      for (int w = 0; w < NW; w++)
         for (int s = 0; s < SETS; s++) begin
            mem_tag[w][s] = '0; mem_v[w][s] = 1'b0;
            ref_tag[w][s] = '0; ref_v[w][s] = 1'b0;
         end
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_hit();
      test_partial_miss();
      test_round_robin();
      test_flush_abort();
      test_priority();
      test_multihit();
      test_reset_mid_compare();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
